// File: rtl/ccip_if_pkg.sv
// CCI-P interface types used by the MMIO CSR responder.
// Covers the c0 Rx MMIO request path and the c2 Tx MMIO response path.
package ccip_if_pkg;

    localparam int CCIP_CLDATA_WIDTH   = 512;
    localparam int CCIP_MMIOADDR_WIDTH = 18;
    localparam int CCIP_MMIODATA_WIDTH = 64;
    localparam int CCIP_TID_WIDTH      = 9;

    typedef logic [CCIP_CLDATA_WIDTH-1:0]   t_ccip_clData;
    typedef logic [CCIP_MMIOADDR_WIDTH-1:0] t_ccip_mmioAddr;
    typedef logic [CCIP_MMIODATA_WIDTH-1:0] t_ccip_mmioData;
    typedef logic [CCIP_TID_WIDTH-1:0]      t_ccip_tid;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    localparam int CCIP_C0RX_HDR_WIDTH = $bits(t_ccip_c0_ReqMmioHdr);

    // The c0 Rx header is shared between memory responses and MMIO requests.
    typedef logic [CCIP_C0RX_HDR_WIDTH-1:0] t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/ccip_mmio_csr_pkg.sv
// CSR map, read-pipeline record and helpers shared by the MMIO CSR responder.
package ccip_mmio_csr_pkg;
    import ccip_if_pkg::*;

    typedef logic [16:0] t_csr_idx;

    localparam t_csr_idx CSR_DFH       = 17'd0;
    localparam t_csr_idx CSR_AFU_ID_L  = 17'd1;
    localparam t_csr_idx CSR_AFU_ID_H  = 17'd2;
    localparam t_csr_idx CSR_RSVD_3    = 17'd3;
    localparam t_csr_idx CSR_RSVD_4    = 17'd4;
    localparam t_csr_idx CSR_SCRATCH   = 17'd5;
    localparam t_csr_idx CSR_CYCLES    = 17'd6;
    localparam t_csr_idx CSR_RD_COUNT  = 17'd7;
    localparam t_csr_idx CSR_USER_BASE = 17'd8;

    typedef struct packed {
        logic      valid;
        t_csr_idx  idx;
        logic      half;
        logic      is_4b;
        t_ccip_tid tid;
    } t_mmio_rd_stage;

    // Replace one 32-bit half of a CSR, keeping the other half.
    function automatic logic [63:0] merge_half(input logic [63:0] old,
                                               input logic [31:0] new32,
                                               input logic        half);
        return half ? {new32, old[31:0]} : {old[63:32], new32};
    endfunction

endpackage

// File: rtl/ccip_mmio_csr_rd_pipe.sv
// Two-stage MMIO read pipeline: stage 1 latches the request and counter
// snapshot, stage 2 selects the CSR value and drives the c2 response.
module ccip_mmio_csr_rd_pipe
    import ccip_if_pkg::*;
    import ccip_mmio_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE     = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L      = 64'h0,
    parameter logic [63:0] AFU_ID_H      = 64'h0,
    parameter int          NUM_USER_CSRS = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  t_mmio_rd_stage                 rdReq,
    input  logic [63:0]                    cycleCount,
    input  logic [63:0]                    rdCountInc,
    input  logic [63:0]                    scratch,
    input  logic [NUM_USER_CSRS-1:0][63:0] userCsr,
    output t_if_ccip_c2_Tx                 c2Tx
);

    t_mmio_rd_stage s1;
    logic [63:0]    s1Snap;
    logic [63:0]    full64;
    logic [63:0]    rspData;

    // Counters are frozen at stage 1 so the returned value reflects request time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= '0;
            s1Snap <= '0;
        end else begin
            s1     <= rdReq;
            s1Snap <= (rdReq.idx == CSR_CYCLES) ? cycleCount : rdCountInc;
        end
    end

    always_comb begin
        full64 = '0;
        case (s1.idx)
            CSR_DFH:                  full64 = DFH_VALUE;
            CSR_AFU_ID_L:             full64 = AFU_ID_L;
            CSR_AFU_ID_H:             full64 = AFU_ID_H;
            CSR_SCRATCH:              full64 = scratch;
            CSR_CYCLES, CSR_RD_COUNT: full64 = s1Snap;
            default: begin
                for (int i = 0; i < NUM_USER_CSRS; i++) begin
                    if (s1.idx == t_csr_idx'(CSR_USER_BASE + i)) begin
                        full64 = userCsr[i];
                    end
                end
            end
        endcase
    end

    assign rspData = s1.is_4b ? {32'h0, (s1.half ? full64[63:32] : full64[31:0])}
                              : full64;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c2Tx <= '0;
        end else begin
            c2Tx <= '0;
            if (s1.valid) begin
                c2Tx.mmioRdValid <= 1'b1;
                c2Tx.hdr.tid     <= s1.tid;
                c2Tx.data        <= rspData;
            end
        end
    end

endmodule

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side CCI-P MMIO responder: DFH, AFU ID, scratch, counters and a bank of
// user CSRs, with fixed two-cycle read responses on c2.
module ccip_mmio_csr_responder
    import ccip_if_pkg::*;
    import ccip_mmio_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE     = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L      = 64'h0,
    parameter logic [63:0] AFU_ID_H      = 64'h0,
    parameter int          NUM_USER_CSRS = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  t_if_ccip_c0_Rx                 sRx_c0,
    output t_if_ccip_c2_Tx                 c2Tx,
    output logic [NUM_USER_CSRS-1:0][63:0] csr_user,
    output logic [NUM_USER_CSRS-1:0]       csr_user_wr
);

    // Handshake: a request is taken in any cycle its valid is high; there is no
    // ready, and each read yields exactly one c2 response two edges later.
    t_ccip_c0_ReqMmioHdr reqHdr;
    t_csr_idx            reqIdx;
    logic                reqHalf;
    logic                reqIs4b;
    logic                wrEn;
    logic                rdEn;
    logic [63:0]         wrData;
    t_mmio_rd_stage      rdReq;

    logic [63:0] scratch;
    logic [63:0] cycleCount;
    logic [63:0] rdCount;
    logic [63:0] rdCountInc;

    assign reqHdr  = t_ccip_c0_ReqMmioHdr'(sRx_c0.hdr);
    assign reqIdx  = reqHdr.address[17:1];
    assign reqHalf = reqHdr.address[0];
    assign reqIs4b = (reqHdr.length == 2'b00);
    assign wrData  = sRx_c0.data[63:0];

    // A write wins if both valids are ever seen together.
    assign wrEn = sRx_c0.mmioWrValid;
    assign rdEn = sRx_c0.mmioRdValid && !sRx_c0.mmioWrValid;

    assign rdCountInc = rdCount + 64'd1;

    always_comb begin
        rdReq       = '0;
        rdReq.valid = rdEn;
        rdReq.idx   = reqIdx;
        rdReq.half  = reqHalf;
        rdReq.is_4b = reqIs4b;
        rdReq.tid   = reqHdr.tid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycleCount <= '0;
            rdCount    <= '0;
        end else begin
            cycleCount <= cycleCount + 64'd1;
            if (rdEn) begin
                rdCount <= rdCountInc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
        end else if (wrEn && reqIdx == CSR_SCRATCH) begin
            scratch <= reqIs4b ? merge_half(scratch, wrData[31:0], reqHalf) : wrData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_user    <= '0;
            csr_user_wr <= '0;
        end else begin
            csr_user_wr <= '0;
            for (int i = 0; i < NUM_USER_CSRS; i++) begin
                if (wrEn && reqIdx == t_csr_idx'(CSR_USER_BASE + i)) begin
                    csr_user[i]    <= reqIs4b ? merge_half(csr_user[i], wrData[31:0], reqHalf)
                                              : wrData;
                    csr_user_wr[i] <= 1'b1;
                end
            end
        end
    end

    ccip_mmio_csr_rd_pipe #(
        .DFH_VALUE     (DFH_VALUE),
        .AFU_ID_L      (AFU_ID_L),
        .AFU_ID_H      (AFU_ID_H),
        .NUM_USER_CSRS (NUM_USER_CSRS)
    ) u_rd_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .rdReq      (rdReq),
        .cycleCount (cycleCount),
        .rdCountInc (rdCountInc),
        .scratch    (scratch),
        .userCsr    (csr_user),
        .c2Tx       (c2Tx)
    );

    rdWrExclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(sRx_c0.mmioRdValid && sRx_c0.mmioWrValid));

    logic unusedBits;
    assign unusedBits = ^{sRx_c0.data[511:64], sRx_c0.rspValid, reqHdr.rsvd};

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed bench for the MMIO CSR responder: drives c0 MMIO requests and
// scoreboards every c2 response for data, tid and exact arrival cycle.
module tb_ccip_mmio_csr_responder;
    import ccip_if_pkg::*;
    import ccip_mmio_csr_pkg::*;

    localparam logic [63:0] DFH   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] AFU_L = 64'h1122_3344_5566_7788;
    localparam logic [63:0] AFU_H = 64'h99AA_BBCC_DDEE_FF00;
    localparam int          N     = 8;
    localparam int          EW    = 105;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] tbCycle  = '0;
    logic [31:0] rstCycle = '0;
    always @(posedge clk) tbCycle <= tbCycle + 32'd1;

    t_if_ccip_c0_Rx          sRx_c0;
    t_if_ccip_c2_Tx          c2Tx;
    logic [N-1:0][63:0]      csr_user;
    logic [N-1:0]            csr_user_wr;

    ccip_mmio_csr_responder #(
        .DFH_VALUE     (DFH),
        .AFU_ID_L      (AFU_L),
        .AFU_ID_H      (AFU_H),
        .NUM_USER_CSRS (N)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sRx_c0      (sRx_c0),
        .c2Tx        (c2Tx),
        .csr_user    (csr_user),
        .csr_user_wr (csr_user_wr)
    );

    // ---------------- scoreboard ----------------
    // Entry: {due cycle[104:73], tid[72:64], data[63:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] monEntry;
    int checks = 0;
    int errors = 0;
    int wrPulseCnt[N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) wrPulseCnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) wrPulseCnt[i] += int'(csr_user_wr[i]);
            if (c2Tx.mmioRdValid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(c2Tx.mmioRdValid), 64'd0);
                end else begin
                    monEntry = exp_q.pop_front();
                    check("rsp_cycle", 64'(tbCycle), 64'(monEntry[104:73]));
                    check("rsp_tid", 64'(c2Tx.hdr.tid), 64'(monEntry[72:64]));
                    check("rsp_data", c2Tx.data, monEntry[63:0]);
                end
            end else if (exp_q.size() != 0 && exp_q[0][104:73] <= tbCycle) begin
                check("rsp_missing", 64'(c2Tx.mmioRdValid), 64'd1);
                monEntry = exp_q.pop_front();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic sendRd(input logic [17:0] addr, input logic [1:0] len,
                          input logic [8:0] tid, input logic [63:0] expData);
        t_ccip_c0_ReqMmioHdr h;
        h = '0;
        h.address = addr;
        h.length  = len;
        h.tid     = tid;
        sRx_c0 = '0;
        sRx_c0.hdr = h;
        sRx_c0.mmioRdValid = 1'b1;
        exp_q.push_back({tbCycle + 32'd2, tid, expData});
        step();
        sRx_c0 = '0;
    endtask

    task automatic sendWr(input logic [17:0] addr, input logic [1:0] len, input logic [63:0] data);
        t_ccip_c0_ReqMmioHdr h;
        h = '0;
        h.address = addr;
        h.length  = len;
        sRx_c0 = '0;
        sRx_c0.hdr  = h;
        sRx_c0.data = 512'(data);
        sRx_c0.mmioWrValid = 1'b1;
        step();
        sRx_c0 = '0;
    endtask

    // Reset discards in-flight reads, so the expected queue is cleared with it.
    task automatic doReset();
        exp_q.delete();
        sRx_c0  = '0;
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_c2_valid", 64'(c2Tx.mmioRdValid), 64'd0);
            check("rst_c2_data", c2Tx.data, 64'd0);
            check("rst_user_wr", 64'(csr_user_wr), 64'd0);
            check("rst_user_any", 64'(|csr_user), 64'd0);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        rstCycle = tbCycle;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sRx_c0 = '0;
        doReset();

        // Fixed-value CSRs, back to back
        sendRd(18'd0, 2'd1, 9'd1, DFH);
        sendRd(18'd2, 2'd1, 9'd2, AFU_L);
        sendRd(18'd4, 2'd1, 9'd3, AFU_H);
        sendRd(18'd6, 2'd1, 9'd4, 64'd0);
        sendRd(18'd8, 2'd1, 9'd5, 64'd0);
        idle(4);

        // Scratch full and half writes, read immediately after
        sendWr(18'd10, 2'd1, 64'hDEAD_BEEF_0123_4567);
        sendWr(18'd11, 2'd0, 64'h0000_0000_CAFE_F00D);
        sendRd(18'd10, 2'd1, 9'd20, 64'hCAFE_F00D_0123_4567);
        sendRd(18'd10, 2'd0, 9'd21, 64'h0000_0000_0123_4567);
        sendRd(18'd11, 2'd0, 9'd22, 64'h0000_0000_CAFE_F00D);
        sendRd(18'd10, 2'd2, 9'd23, 64'hCAFE_F00D_0123_4567);
        sendRd(18'd10, 2'd3, 9'd24, 64'hCAFE_F00D_0123_4567);
        idle(4);

        // Read count burst: each read of index 7 includes itself
        doReset();
        for (int i = 0; i < 100; i++) begin
            sendRd(18'd14, 2'd1, 9'(i), 64'(i + 1));
        end
        idle(3);
        sendRd(18'd14, 2'd1, 9'd200, 64'd101);
        idle(4);

        // User CSR at top of range, then out-of-range and RO writes
        sendWr(18'd30, 2'd1, 64'h5);
        @(negedge clk);
        check("user_wr_pulse", 64'(csr_user_wr), 64'h80);
        check("user7_val", csr_user[7], 64'h5);
        sendWr(18'd32, 2'd1, 64'hFFFF);
        sendWr(18'd12, 2'd1, 64'hFFFF);
        sendWr(18'd17, 2'd0, 64'hFFFF_FFFF_1234_5678);
        @(negedge clk);
        check("user_wr_pulse0", 64'(csr_user_wr), 64'h01);
        @(negedge clk);
        check("user_wr_clear", 64'(csr_user_wr), 64'h0);
        for (int i = 0; i < N; i++) begin
            check("user_val", csr_user[i],
                  (i == 7) ? 64'h5 : ((i == 0) ? 64'h1234_5678_0000_0000 : 64'h0));
            check("user_pulses", 64'(wrPulseCnt[i]), ((i == 7) || (i == 0)) ? 64'd1 : 64'd0);
        end
        sendRd(18'd32, 2'd1, 9'd10, 64'd0);
        sendRd(18'd12, 2'd1, 9'd11, 64'(tbCycle - rstCycle));
        sendRd(18'd30, 2'd1, 9'd12, 64'h5);
        sendRd(18'd31, 2'd0, 9'd13, 64'h0);
        sendRd(18'd17, 2'd0, 9'd14, 64'h1234_5678);
        sendRd(18'd16, 2'd0, 9'd15, 64'h0);
        idle(4);

        // Reset one cycle after a read: that read never responds
        sendWr(18'd10, 2'd1, 64'h1111);
        sendWr(18'd16, 2'd1, 64'h2222);
        sendRd(18'd10, 2'd1, 9'h55, 64'h1111);
        doReset();
        @(negedge clk);
        check("post_rst_user0", csr_user[0], 64'd0);
        sendRd(18'd10, 2'd1, 9'd30, 64'd0);
        sendRd(18'd16, 2'd1, 9'd31, 64'd0);
        idle(4);

        // Cycle counter sampled at two requests ten cycles apart
        sendRd(18'd12, 2'd1, 9'd40, 64'(tbCycle - rstCycle));
        idle(9);
        sendRd(18'd12, 2'd1, 9'd41, 64'(tbCycle - rstCycle));
        idle(6);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccip_mmio_csr_responder.md
# ccip_mmio_csr_responder

AFU-side CCI-P MMIO responder. Consumes host MMIO read/write requests from the c0 Rx channel, which the CCI-P platform shim delivers in the AFU clock domain. Returns read responses on the c2 Tx channel. Implements the standard device feature header (DFH), AFU ID, scratch and status CSRs, plus a bank of user-writable CSRs exported to AFU logic.

## Interface
Parameters:
- `DFH_VALUE`, 64'h1000_0000_0000_0000: constant returned at CSR index 0.
- `AFU_ID_L`, 64'h0: AFU GUID low half, index 1.
- `AFU_ID_H`, 64'h0: AFU GUID high half, index 2.
- `NUM_USER_CSRS`, 8: user RW CSRs, indices 8 .. 8+N-1; range 1..32.

Ports:
- `clk`  in  1: AFU CCI-P clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sRx_c0`  in  t_if_ccip_c0_Rx: c0 Rx channel.
  - Only `mmioRdValid`, `mmioWrValid`, `hdr` (as t_ccip_c0_ReqMmioHdr) and `data` are used.
- `c2Tx`  out  t_if_ccip_c2_Tx: MMIO read response (`mmioRdValid`, `hdr.tid`, `data`).
- `csr_user`  out  NUM_USER_CSRS x 64: current user CSR values.
- `csr_user_wr`  out  NUM_USER_CSRS: one-cycle pulse when the corresponding user CSR is written.

## Operation
- Request decode:
  - `hdr.address` is in 4-byte units.
  - 8-byte CSR index = address[17:1]; half select = address[0].
  - `hdr.length` 0 = 4B, 1 = 8B, other values are treated as 8B.
- CSR map (by 8B index):
  - 0: DFH, RO.
  - 1: AFU_ID_L, RO.
  - 2: AFU_ID_H, RO.
  - 3, 4: reserved, read 0.
  - 5: scratch, RW, reset 0.
  - 6: cycle counter, RO. Free-running 64-bit, +1 every cycle out of reset, wraps at 2^64.
  - 7: MMIO read count, RO. +1 per accepted read; wraps.
  - 8+: user CSRs, RW, reset 0.
  - All other indices read 0.
- Writes:
  - 8B write replaces all 64 bits.
  - 4B write replaces only the selected 32-bit half with data[31:0]; the other half is unchanged.
  - Writes to RO, reserved or out-of-range indices are silently dropped; no response is produced for writes.
- Reads:
  - Exactly one c2 response per read, carrying the request `tid`.
  - 8B read returns the full 64 bits.
  - 4B read returns the selected half in data[31:0] and zero in data[63:32].
  - Out-of-range reads return 0.
- `mmioRdValid` and `mmioWrValid` are never asserted together; if they are, the write is processed and the read is dropped.
  - Simulation assertion flags this case.

## Timing
- No back-pressure. c2 has no flow control, so one request per cycle is sustained indefinitely.
- Write at edge T: CSR updated at edge T+1; `csr_user_wr` high for the single cycle after T+1 edge.
- Read latency is fixed at 2 cycles:
  - Stage 1 (edge T+1) registers index, half, length, tid.
  - Stage 2 (edge T+2) registers data and asserts `c2Tx.mmioRdValid` for one cycle.
  - Responses are in request order.
- Read-after-write: a read captured at edge T+1 or later observes a write captured at edge T.
  - A read captured at the same edge as a write is impossible (see above).
- Cycle counter and read count are sampled in stage 1.
- Read count increments at the stage-1 edge, before its own sample, so a read of index 7 returns the count including itself.
- Reset (`reset_n` low, any time):
  - All CSRs 0 and counters 0.
  - Both pipeline stages cleared; in-flight reads are discarded with no response.
  - `c2Tx` all zero; `csr_user_wr` 0.
  - First request accepted at the first edge with `reset_n` high.

## Structure
- Package `ccip_mmio_csr_pkg`:
  - CSR index localparams (`CSR_DFH` .. `CSR_USER_BASE`).
  - `t_csr_idx` (17-bit).
  - Stage-1 record struct `t_mmio_rd_stage` (valid, idx, half, is_4b, tid).
  - Helper function `merge_half(old, new32, half)`.
- Sub-module `ccip_mmio_csr_rd_pipe`:
  - Holds the two read stages, read-data mux and response formatting.
  - The top owns the CSR storage, counters and write decode.
- Uses existing `ccip_if_pkg` types; no new interface definitions.

## Test plan
- Reset then read indices 0, 1, 2, 3 with tids 1..4:
  - Four responses at T+2..T+5 with `DFH_VALUE`, `AFU_ID_L`, `AFU_ID_H`, 0 and tids 1..4.
  - No responses during reset.
- 8B write 64'hDEAD_BEEF_0123_4567 to scratch, then 4B write 32'hCAFE_F00D at address 11 (upper half):
  - 8B read returns 64'hCAFE_F00D_0123_4567.
  - 4B read at address 10 returns 64'h0000_0000_0123_4567.
- 100 back-to-back reads, one per cycle, of index 7 with tid = i:
  - Response i arrives exactly 2 cycles after its request with data i+1 and tid i.
- Write index 8+k (k = N-1) with 64'h5, then write index 8+N and index 6:
  - `csr_user[k]` = 5 and `csr_user_wr[k]` pulses once.
  - Out-of-range and RO writes change nothing.
  - A subsequent read of index 8+N returns 0.
- Issue a read, assert `reset_n` low in the following cycle:
  - No c2 response ever appears.
  - Scratch and user CSRs read 0 after release.
- Read index 6 at two requests 10 cycles apart: data values differ by exactly 10.
